// File: rtl/lab_serial_borrow_sub.sv
// lab_serial_borrow_sub
//   Multi-cycle subtractor: diff = x - y - bin (modulo 2^WIDTH).
//   DIGIT bits are resolved per clock through a ripple-borrow slice. The borrow
//   between digits is carried in a register, so the combinational path is only
//   DIGIT bits long regardless of WIDTH. Latency is N = WIDTH/DIGIT clocks.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous, active-high reset (aborts any operation in flight)
//   start  request, sampled only in IDLE
//   x, y   minuend / subtrahend, captured on an accepted start
//   bin    borrow-in, captured on an accepted start
//   busy   high while an operation is running
//   done   one-cycle pulse; diff and flags are valid
//   diff   x - y - bin
//   bout   unsigned borrow out (x < y + bin)
//   ovf    two's-complement overflow
//   zero   diff == 0
//
// States
//   state  | meaning
//   IDLE   | waiting for start; results held
//   RUN    | one digit subtracted per clock, N clocks total

module lab_serial_borrow_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_sh;
    logic             x_msb;
    logic             y_msb;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] d_slice;
    logic [DIGIT:0]   b_chain;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;

    // Ripple-borrow slice over the low DIGIT bits of the operand shifters.
    // A bit borrows when a < b + c.
    always_comb begin
        d_slice    = '0;
        b_chain    = '0;
        b_chain[0] = brw;
        for (int i = 0; i < DIGIT; i++) begin
            d_slice[i]   = x_sh[i] ^ y_sh[i] ^ b_chain[i];
            b_chain[i+1] = (~x_sh[i] & y_sh[i]) | (~(x_sh[i] ^ y_sh[i]) & b_chain[i]);
        end
    end

    // Result digits enter from the MSB end. Only WIDTH-DIGIT bits of earlier
    // digits need to be stored; the newest digit comes straight from the slice.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign res_next = d_slice;
        end else begin : g_multi
            logic [WIDTH-DIGIT-1:0] res_sh;

            assign res_next = {d_slice, res_sh};

            always_ff @(posedge clk) begin
                if (rst) begin
                    res_sh <= '0;
                end else if (state == S_RUN) begin
                    res_sh <= res_next[WIDTH-1:DIGIT];
                end
            end
        end
    endgenerate

    // Overflow only possible when operand signs differ; bin acts through diff.
    assign ovf_next = (x_msb != y_msb) && (res_next[WIDTH-1] != x_msb);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            x_sh  <= '0;
            y_sh  <= '0;
            x_msb <= 1'b0;
            y_msb <= 1'b0;
            brw   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    x_sh  <= x;
                    y_sh  <= y;
                    x_msb <= x[WIDTH-1];
                    y_msb <= y[WIDTH-1];
                    brw   <= bin;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= S_RUN;
                end
            end else begin
                x_sh <= x_sh >> DIGIT;
                y_sh <= y_sh >> DIGIT;
                brw  <= b_chain[DIGIT];
                cnt  <= cnt + CW'(1);
                if (cnt == LAST) begin
                    diff  <= res_next;
                    bout  <= b_chain[DIGIT];
                    ovf   <= ovf_next;
                    zero  <= (res_next == '0);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_lab_serial_borrow_sub.sv
// tb_lab_serial_borrow_sub
//   Instance 0: WIDTH=4, DIGIT=1. Instances 1..4: WIDTH=8, DIGIT=1,2,4,8.
//   A cycle-level reference model tracks every instance; outputs are compared
//   each cycle on the falling edge, plus literal checks on directed cases.

module tb_lab_serial_borrow_sub;

    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       st   [NI];
    logic [7:0] xa   [NI];
    logic [7:0] ya   [NI];
    logic       ba   [NI];
    logic       busy_o [NI];
    logic       done_o [NI];
    logic       bout_o [NI];
    logic       ovf_o  [NI];
    logic       zero_o [NI];
    logic [3:0] diff4;
    logic [7:0] diff8 [1:4];

    lab_serial_borrow_sub #(.WIDTH(4), .DIGIT(1)) u_w4 (
        .clk(clk), .rst(rst), .start(st[0]), .x(xa[0][3:0]), .y(ya[0][3:0]),
        .bin(ba[0]), .busy(busy_o[0]), .done(done_o[0]), .diff(diff4),
        .bout(bout_o[0]), .ovf(ovf_o[0]), .zero(zero_o[0])
    );

    for (genvar g = 1; g <= 4; g++) begin : g_w8
        lab_serial_borrow_sub #(.WIDTH(8), .DIGIT(1 << (g - 1))) u_dut (
            .clk(clk), .rst(rst), .start(st[g]), .x(xa[g]), .y(ya[g]),
            .bin(ba[g]), .busy(busy_o[g]), .done(done_o[g]), .diff(diff8[g]),
            .bout(bout_o[g]), .ovf(ovf_o[g]), .zero(zero_o[g])
        );
    end

    int n_chk  = 0;
    int n_fail = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int wid(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 4 : (8 >> (i - 1));
    endfunction

    function automatic logic [7:0] dut_diff(input int i);
        return (i == 0) ? {4'h0, diff4} : diff8[i];
    endfunction

    // Plain-arithmetic reference for one subtraction.
    task automatic ref_sub(input int w, input int x, input int y, input int b,
                           output int d, output int bo, output int ov, output int z);
        int m, h, ux, uy, r, sx, sy, sr;
        m  = (1 << w) - 1;
        h  = 1 << (w - 1);
        ux = x & m;
        uy = y & m;
        r  = ux - uy - b;
        sx = (ux >= h) ? ux - (1 << w) : ux;
        sy = (uy >= h) ? uy - (1 << w) : uy;
        sr = sx - sy - b;
        d  = r & m;
        bo = (r < 0) ? 1 : 0;
        ov = (sr < -h || sr > h - 1) ? 1 : 0;
        z  = (d == 0) ? 1 : 0;
    endtask

    // Reference model state
    int m_rem [NI];
    int m_busy[NI], m_done[NI], m_diff[NI], m_bout[NI], m_ovf[NI], m_zero[NI];
    int p_diff[NI], p_bout[NI], p_ovf[NI], p_zero[NI];
    int n_acc [NI];
    int n_done[NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_rem[i] = 0; m_busy[i] = 0; m_done[i] = 0;
                m_diff[i] = 0; m_bout[i] = 0; m_ovf[i] = 0; m_zero[i] = 0;
            end else begin
                m_done[i] = 0;
                if (m_rem[i] > 0) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_done[i] = 1;
                        m_busy[i] = 0;
                        m_diff[i] = p_diff[i];
                        m_bout[i] = p_bout[i];
                        m_ovf[i]  = p_ovf[i];
                        m_zero[i] = p_zero[i];
                    end
                end else if (st[i]) begin
                    ref_sub(wid(i), int'(xa[i]), int'(ya[i]), int'(ba[i]),
                            p_diff[i], p_bout[i], p_ovf[i], p_zero[i]);
                    m_rem[i]  = lat(i);
                    m_busy[i] = 1;
                    n_acc[i]++;
                end
            end
        end
    end

    // Single compare process against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(m_busy[i]));
                chk($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(m_done[i]));
                chk($sformatf("diff[%0d]", i), 32'(dut_diff(i)), 32'(m_diff[i]));
                chk($sformatf("bout[%0d]", i), 32'(bout_o[i]), 32'(m_bout[i]));
                chk($sformatf("ovf[%0d]", i), 32'(ovf_o[i]), 32'(m_ovf[i]));
                chk($sformatf("zero[%0d]", i), 32'(zero_o[i]), 32'(m_zero[i]));
                if (done_o[i]) n_done[i]++;
            end
        end
    end

    // Issue one operation from a falling edge; returns edges from accept to
    // done and the number of busy samples seen before done.
    task automatic op(input int i, input logic [7:0] x, input logic [7:0] y, input logic b,
                      output int l, output int bc);
        xa[i] = x; ya[i] = y; ba[i] = b; st[i] = 1'b1;
        l = -1; bc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) st[i] = 1'b0;
            if (done_o[i]) begin
                l = c - 1;
                break;
            end
            if (busy_o[i]) bc++;
        end
        chk($sformatf("done_seen[%0d]", i), 32'(l >= 0), 32'd1);
    endtask

    typedef struct {
        logic [7:0] x, y;
        logic       b;
        logic [7:0] d;
        logic       bo, ov, z;
    } vec_t;

    vec_t edge_v[4];

    initial begin
        int l, bc, first, second, seen;

        edge_v[0] = '{x: 8'h00, y: 8'hFF, b: 1'b1, d: 8'h00, bo: 1'b1, ov: 1'b0, z: 1'b1};
        edge_v[1] = '{x: 8'hFF, y: 8'h00, b: 1'b0, d: 8'hFF, bo: 1'b0, ov: 1'b0, z: 1'b0};
        edge_v[2] = '{x: 8'h80, y: 8'h01, b: 1'b0, d: 8'h7F, bo: 1'b0, ov: 1'b1, z: 1'b0};
        edge_v[3] = '{x: 8'h7F, y: 8'hFF, b: 1'b1, d: 8'h7F, bo: 1'b1, ov: 1'b0, z: 1'b0};

        for (int i = 0; i < NI; i++) begin
            st[i] = 1'b0; xa[i] = '0; ya[i] = '0; ba[i] = 1'b0;
            n_acc[i] = 0; n_done[i] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_busy[%0d]", i), 32'(busy_o[i]), 32'd0);
            chk($sformatf("rst_done[%0d]", i), 32'(done_o[i]), 32'd0);
            chk($sformatf("rst_diff[%0d]", i), 32'(dut_diff(i)), 32'd0);
            chk($sformatf("rst_flags[%0d]", i), {29'd0, bout_o[i], ovf_o[i], zero_o[i]}, 32'd0);
        end
        rst = 1'b0;
        cmp_en = 1'b1;

        // Directed WIDTH=4 cases
        op(0, 8'hC, 8'h5, 1'b1, l, bc);
        chk("t1_lat", 32'(l), 32'd4);
        chk("t1_busy_cycles", 32'(bc), 32'd4);
        chk("t1_diff", 32'(diff4), 32'h6);
        chk("t1_flags", {29'd0, bout_o[0], ovf_o[0], zero_o[0]}, 32'b010);
        chk("t1_model_diff", 32'(m_diff[0]), 32'h6);
        @(negedge clk);
        chk("t1_done_once", 32'(done_o[0]), 32'd0);

        op(0, 8'h5, 8'hD, 1'b0, l, bc);
        chk("t2a_diff", 32'(diff4), 32'h8);
        chk("t2a_flags", {29'd0, bout_o[0], ovf_o[0], zero_o[0]}, 32'b110);
        chk("t2a_model_ovf", 32'(m_ovf[0]), 32'd1);
        // 6 - (-3) - 1 = 8 does not fit in 4-bit signed, so ovf is set
        op(0, 8'h6, 8'hD, 1'b1, l, bc);
        chk("t2b_diff", 32'(diff4), 32'h8);
        chk("t2b_flags", {29'd0, bout_o[0], ovf_o[0], zero_o[0]}, 32'b110);

        op(0, 8'h9, 8'h9, 1'b0, l, bc);
        chk("t3a_diff", 32'(diff4), 32'h0);
        chk("t3a_flags", {29'd0, bout_o[0], ovf_o[0], zero_o[0]}, 32'b001);
        op(0, 8'h5, 8'h5, 1'b1, l, bc);
        chk("t3b_diff", 32'(diff4), 32'hF);
        chk("t3b_flags", {29'd0, bout_o[0], ovf_o[0], zero_o[0]}, 32'b100);
        chk("t3b_model_zero", 32'(m_zero[0]), 32'd0);

        // Starts and operand changes while busy are ignored
        xa[0] = 8'h3; ya[0] = 8'h1; ba[0] = 1'b0; st[0] = 1'b1;
        first = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done_o[0]) begin
                first = c;
                break;
            end
            st[0] = 1'b1;
            xa[0] = 8'($urandom);
            ya[0] = 8'($urandom);
            ba[0] = 1'($urandom_range(1));
        end
        chk("t4_done_seen", 32'(first >= 0), 32'd1);
        chk("t4_lat", 32'(first - 1), 32'd4);
        chk("t4_diff", 32'(diff4), 32'h2);
        // Start in the done cycle is accepted
        xa[0] = 8'hA; ya[0] = 8'h3; ba[0] = 1'b0; st[0] = 1'b1;
        second = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) st[0] = 1'b0;
            if (done_o[0]) begin
                second = c;
                break;
            end
        end
        chk("t4_back_to_back", 32'(second), 32'd5);
        chk("t4b_diff", 32'(diff4), 32'h7);

        // Reset during RUN aborts the operation
        xa[0] = 8'hC; ya[0] = 8'h5; ba[0] = 1'b1; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        chk("t5_busy_before", 32'(busy_o[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", 32'(busy_o[0]), 32'd0);
        chk("t5_done", 32'(done_o[0]), 32'd0);
        chk("t5_diff", 32'(diff4), 32'h0);
        chk("t5_flags", {29'd0, bout_o[0], ovf_o[0], zero_o[0]}, 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_o[0]) seen++;
        end
        chk("t5_no_done", 32'(seen), 32'd0);

        // WIDTH=8 boundary vectors on every DIGIT
        for (int v = 0; v < 4; v++) begin
            for (int i = 1; i <= 4; i++) begin
                op(i, edge_v[v].x, edge_v[v].y, edge_v[v].b, l, bc);
                chk($sformatf("e%0d_lat[%0d]", v, i), 32'(l), 32'(lat(i)));
                chk($sformatf("e%0d_diff[%0d]", v, i), 32'(diff8[i]), 32'(edge_v[v].d));
                chk($sformatf("e%0d_flags[%0d]", v, i), {29'd0, bout_o[i], ovf_o[i], zero_o[i]},
                    {29'd0, edge_v[v].bo, edge_v[v].ov, edge_v[v].z});
            end
        end

        // Randomized traffic on all instances
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_acc[i] = 0;
            n_done[i] = 0;
        end
        for (int c = 0; c < 12000; c++) begin
            for (int i = 0; i < NI; i++) begin
                st[i] = ($urandom_range(7) != 0);
                xa[i] = 8'($urandom);
                ya[i] = 8'($urandom);
                ba[i] = 1'($urandom_range(1));
            end
            @(negedge clk);
        end
        for (int i = 0; i < NI; i++) st[i] = 1'b0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rand_done_count[%0d]", i), 32'(n_done[i]), 32'(n_acc[i]));
            if (i > 0) chk($sformatf("rand_vectors[%0d]", i), 32'(n_acc[i] >= 1000), 32'd1);
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
